// File: rtl/mac_pkg.sv
// Shared defaults, state encoding and saturating-add helper for the mac_dot_pipe datapath.
package mac_pkg;

  localparam int unsigned DefBw     = 4;
  localparam int unsigned DefPsumBw = 16;
  localparam int unsigned DefLanes  = 4;
  localparam int unsigned DefProdBw = 2 * DefBw + 1;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StFull
  } mac_state_e;

  // Wide add clamped to the signed range of a w-bit result.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned        w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/mac_lane_mul.sv
// One MAC lane: extends the activation per act_signed_i, multiplies by the signed weight and
// registers the exact (2*BW+1)-bit product when en_i is high.
module mac_lane_mul
  import mac_pkg::*;
#(
  parameter int unsigned BW = DefBw
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                act_signed_i,
  input  logic [BW-1:0]       a_i,
  input  logic [BW-1:0]       w_i,
  output logic signed [2*BW:0] prod_o
);

  localparam int unsigned ProdBw = 2 * BW + 1;

  logic signed [BW:0]        a_ext;
  logic signed [BW:0]        w_ext;
  logic signed [ProdBw-1:0]  prod_d;
  logic signed [ProdBw-1:0]  prod_q;

  always_comb begin
    a_ext  = act_signed_i ? {a_i[BW-1], a_i} : {1'b0, a_i};
    w_ext  = {w_i[BW-1], w_i};
    prod_d = ProdBw'(a_ext) * ProdBw'(w_ext);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q <= '0;
    end else if (en_i) begin
      prod_q <= prod_d;
    end
  end

  assign prod_o = prod_q;

endmodule

// File: rtl/mac_dot_pipe.sv
// Two-stage weight-stationary multi-lane MAC producing one signed dot product per vector.
// Define MAC_SAT_EN for saturating accumulation; otherwise the accumulator wraps.
module mac_dot_pipe
  import mac_pkg::*;
#(
  parameter int unsigned BW      = DefBw,
  parameter int unsigned PSUM_BW = DefPsumBw,
  parameter int unsigned LANES   = DefLanes
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      w_load,
  input  logic [LANES*BW-1:0]       w_in,
  input  logic                      act_signed,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*BW-1:0]       a_in,
  input  logic                      in_last,
  input  logic                      acc_clr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [PSUM_BW-1:0] psum_out,
  output logic                      ovf
);

  localparam int unsigned ProdBw = 2 * BW + 1;

  logic [LANES*BW-1:0]       w_q;
  logic                      s1_valid_q, s1_valid_d;
  logic                      s1_last_q, s1_last_d;
  logic signed [PSUM_BW-1:0] acc_q, acc_d;
  logic signed [PSUM_BW-1:0] psum_q, psum_d;
  logic                      ovf_acc_q, ovf_acc_d;
  logic                      ovf_q, ovf_d;
  logic                      part_q, part_d;
  mac_state_e                state_q, state_d;

  logic signed [ProdBw-1:0]  prod [LANES];
  logic signed [PSUM_BW-1:0] sum;
  logic signed [PSUM_BW-1:0] nxt;
  logic signed [63:0]        full_sum;
  logic                      add_ovf;
  logic                      adv, accept, stage2, wr_res;
`ifdef MAC_SAT_EN
  logic signed [63:0]        sat_sum;
`endif

  assign out_valid = (state_q == StFull);
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv && !acc_clr;
  assign accept    = in_valid && in_ready;
  assign stage2    = adv && s1_valid_q && !acc_clr;
  assign wr_res    = stage2 && s1_last_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane_mul #(
      .BW(BW)
    ) u_lane (
      .clk_i       (clk),
      .rst_ni      (reset_n),
      .en_i        (accept),
      .act_signed_i(act_signed),
      .a_i         (a_in[i*BW +: BW]),
      .w_i         (w_q[i*BW +: BW]),
      .prod_o      (prod[i])
    );
  end

  // Lane sum cannot overflow PSUM_BW; only the accumulate step is range-checked.
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + PSUM_BW'(prod[i]);
    end
    full_sum = 64'(acc_q) + 64'(sum);
`ifdef MAC_SAT_EN
    sat_sum = sat_add(64'(acc_q), 64'(sum), PSUM_BW);
    nxt     = sat_sum[PSUM_BW-1:0];
    add_ovf = (sat_sum != full_sum);
`else
    nxt     = full_sum[PSUM_BW-1:0];
    add_ovf = (64'(nxt) != full_sum);
`endif
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    acc_d      = acc_q;
    ovf_acc_d  = ovf_acc_q;
    psum_d     = psum_q;
    ovf_d      = ovf_q;
    part_d     = part_q;
    if (acc_clr) begin
      s1_valid_d = 1'b0;
      acc_d      = '0;
      ovf_acc_d  = 1'b0;
      part_d     = 1'b0;
    end else if (adv) begin
      s1_valid_d = accept;
      if (accept) s1_last_d = in_last;
      if (stage2) begin
        if (s1_last_q) begin
          psum_d    = nxt;
          ovf_d     = ovf_acc_q | add_ovf;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
          part_d    = 1'b0;
        end else begin
          acc_d     = nxt;
          ovf_acc_d = ovf_acc_q | add_ovf;
          part_d    = 1'b1;
        end
      end
    end
  end

  // FULL while a result is held unconsumed; otherwise IDLE/ACC track partial-sum presence.
  always_comb begin
    state_d = part_d ? StAcc : StIdle;
    if (state_q == StFull && !out_ready) state_d = StFull;
    if (wr_res) state_d = StFull;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_q        <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      acc_q      <= '0;
      ovf_acc_q  <= 1'b0;
      psum_q     <= '0;
      ovf_q      <= 1'b0;
      part_q     <= 1'b0;
      state_q    <= StIdle;
    end else begin
      if (w_load) w_q <= w_in;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      acc_q      <= acc_d;
      ovf_acc_q  <= ovf_acc_d;
      psum_q     <= psum_d;
      ovf_q      <= ovf_d;
      part_q     <= part_d;
      state_q    <= state_d;
    end
  end

  assign psum_out = psum_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_mac_dot_pipe.sv
// Bench for mac_dot_pipe: integer reference model of accepted beats plus directed literal checks.
module tb_mac_dot_pipe;

  localparam int LANES = 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               w_load = 1'b0;
  logic [15:0]        w_in = '0;
  logic               act_signed = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [15:0]        a_in = '0;
  logic               in_last = 1'b0;
  logic               acc_clr = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] psum_out;
  logic               ovf;

  mac_dot_pipe u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .w_load    (w_load),
    .w_in      (w_in),
    .act_signed(act_signed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .in_last   (in_last),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .psum_out  (psum_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int m_w [LANES];
  int m_acc = 0;
  bit m_ovf = 1'b0;
  int m_t;
  int exp_q [$];
  bit expo_q [$];

  function automatic int nib_val(input logic [15:0] v, input int i, input bit sgn);
    logic [3:0] n;
    n = v[i*4 +: 4];
    if (sgn) return int'($signed(n));
    return int'(n);
  endfunction

  function automatic int lane_sum(input logic [15:0] a, input bit sgn);
    int s = 0;
    for (int i = 0; i < LANES; i++) s += nib_val(a, i, sgn) * m_w[i];
    return s;
  endfunction

`ifndef MAC_SAT_EN
  function automatic int wrap16(input int t);
    logic signed [15:0] v;
    v = t[15:0];
    return int'(v);
  endfunction
`endif

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference model: acts on each accepted beat at the clock edge.
  initial begin
    for (int i = 0; i < LANES; i++) m_w[i] = 0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        exp_q.delete();
        expo_q.delete();
        m_acc = 0;
        m_ovf = 1'b0;
        for (int i = 0; i < LANES; i++) m_w[i] = 0;
      end else begin
        if (out_valid && out_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          void'(expo_q.pop_front());
        end
        if (acc_clr) begin
          m_acc = 0;
          m_ovf = 1'b0;
        end else if (in_valid && in_ready) begin
          m_t = m_acc + lane_sum(a_in, act_signed);
          if (m_t > 32767 || m_t < -32768) begin
            m_ovf = 1'b1;
`ifdef MAC_SAT_EN
            m_t = (m_t > 32767) ? 32767 : -32768;
`else
            m_t = wrap16(m_t);
`endif
          end
          if (in_last) begin
            exp_q.push_back(m_t);
            expo_q.push_back(m_ovf);
            m_acc = 0;
            m_ovf = 1'b0;
          end else begin
            m_acc = m_t;
          end
        end
        if (w_load) for (int i = 0; i < LANES; i++) m_w[i] = nib_val(w_in, i, 1'b1);
      end
    end
  end

  // Compare every presented result against the model's head entry.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL model_cmp: result %0d presented, none expected", psum_out);
        end else if (int'(psum_out) != exp_q[0] || ovf != expo_q[0]) begin
          n_bad++;
          $display("FAIL model_cmp: got psum %0d ovf %0d, expected psum %0d ovf %0d",
                   psum_out, ovf, exp_q[0], expo_q[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] a, input bit sgn, input bit last, output int stalls);
    bit ok;
    a_in       = a;
    act_signed = sgn;
    in_last    = last;
    in_valid   = 1'b1;
    stalls     = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      ok = in_ready;
      step();
      if (ok) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      stalls++;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL beat_accept: beat not accepted within 100 cycles");
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: out_valid not seen within 20 cycles", name);
  endtask

  task automatic load_w(input logic [15:0] w);
    w_in   = w;
    w_load = 1'b1;
    step();
    w_load = 1'b0;
  endtask

  int st;
  int tot;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_psum", int'(psum_out), 0);
    check("rst_ovf", int'(ovf), 0);
    reset_n = 1'b1;
    step();

    // 1: single beat, latency two cycles
    load_w(16'h4321);
    beat(16'h1111, 1'b1, 1'b1, st);
    @(negedge clk);
    check("t1_valid_t1", int'(out_valid), 0);
    @(negedge clk);
    check("t1_valid_t2", int'(out_valid), 1);
    check("t1_psum", int'(psum_out), 10);
    check("t1_ovf", int'(ovf), 0);
    step();

    // 2: unsigned vs signed activations with negative weights
    load_w(16'hFFFF);
    beat(16'hFFFF, 1'b0, 1'b1, st);
    wait_valid("t2a");
    check("t2_unsigned", int'(psum_out), -60);
    step();
    beat(16'hFFFF, 1'b1, 1'b1, st);
    wait_valid("t2b");
    check("t2_signed", int'(psum_out), 4);
    step();

    // 3: two back-to-back 3-beat vectors, no stalls
    load_w(16'h1111);
    tot = 0;
    for (int v = 0; v < 2; v++) begin
      for (int b = 0; b < 3; b++) begin
        beat(16'h2222, 1'b1, b == 2, st);
        tot += st;
      end
    end
    check("t3_no_stall", tot, 0);
    wait_valid("t3");
    check("t3_psum", int'(psum_out), 24);
    step();
    step();

    // 4: backpressure while the next vector streams in
    out_ready = 1'b0;
    tot = 0;
    fork
      begin
        for (int b = 0; b < 6; b++) begin
          beat(16'h2222, 1'b1, (b % 3) == 2, st);
          tot += st;
        end
      end
      begin
        wait_valid("t4_first");
        repeat (5) begin
          @(negedge clk);
          check("t4_hold", int'(psum_out), 24);
          check("t4_in_ready_low", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    check("t4_stalled", int'(tot > 0), 1);
    wait_valid("t4_second");
    check("t4_second", int'(psum_out), 24);
    step();

    // 5: long vector overflowing the accumulator
    load_w(16'h8888);
    for (int b = 0; b < 200; b++) beat(16'h8888, 1'b1, b == 199, st);
    wait_valid("t5");
`ifdef MAC_SAT_EN
    check("t5_psum", int'(psum_out), 32767);
`else
    check("t5_psum", int'(psum_out), -14336);
`endif
    check("t5_ovf", int'(ovf), 1);
    step();

    // 6a: acc_clr mid-vector drops partial and the concurrent beat
    load_w(16'h1111);
    beat(16'h2222, 1'b1, 1'b0, st);
    beat(16'h2222, 1'b1, 1'b0, st);
    acc_clr  = 1'b1;
    in_valid = 1'b1;
    in_last  = 1'b1;
    a_in     = 16'h5555;
    @(negedge clk);
    check("t6_clr_in_ready", int'(in_ready), 0);
    step();
    acc_clr  = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    beat(16'h1111, 1'b1, 1'b1, st);
    wait_valid("t6a");
    check("t6_after_clr", int'(psum_out), 4);
    step();

    // 6b: beat concurrent with w_load uses the old weights
    w_in   = 16'h2222;
    w_load = 1'b1;
    beat(16'h1111, 1'b1, 1'b1, st);
    w_load = 1'b0;
    wait_valid("t6b");
    check("t6_old_w", int'(psum_out), 4);
    step();
    beat(16'h1111, 1'b1, 1'b1, st);
    wait_valid("t6c");
    check("t6_new_w", int'(psum_out), 8);
    step();

    // 6c: reset mid-vector
    beat(16'h1111, 1'b1, 1'b0, st);
    reset_n = 1'b0;
    @(negedge clk);
    check("t6_rst_valid", int'(out_valid), 0);
    check("t6_rst_psum", int'(psum_out), 0);
    check("t6_rst_ovf", int'(ovf), 0);
    check("t6_rst_in_ready", int'(in_ready), 1);
    step();
    reset_n = 1'b1;
    step();
    beat(16'h1111, 1'b1, 1'b1, st);
    wait_valid("t6d");
    check("t6_rst_weights", int'(psum_out), 0);
    step();

    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
